// File: rtl/alu_op_sequencer.sv
// EX-stage ALU operation decoder with a fixed-latency MUL/DIV sequencer.
// Decodes ALUOp/Funct7/Funct3 into a widened operation code and, for RV32M
// ops, issues a start pulse, stalls the pipeline for the op's latency and
// flags the cycle in which the muldiv result is valid.
//
// Handshake: md_start is a single-cycle pulse in the issue cycle (the
// pipeline is stalled from that same cycle); stall stays high for exactly
// LAT cycles; md_result_valid pulses for one cycle at issue+LAT, which is
// also the cycle in which the held instruction advances.
module alu_op_sequencer #(
    parameter int OP_W      = 5,
    parameter int EN_M      = 1,
    parameter int MUL_LAT   = 3,
    parameter int DIV_LAT   = 33,
    parameter int DIV0_FAST = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            kill,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            b_is_zero,
    output logic [OP_W-1:0] Operation,
    output logic            illegal,
    output logic            md_start,
    output logic            stall,
    output logic            busy,
    output logic            md_result_valid
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = ($clog2(MAX_LAT) > 0) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_OR    = 5'b00001;
    localparam logic [4:0] OP_XOR   = 5'b00010;
    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SRL   = 5'b00101;
    localparam logic [4:0] OP_SUB   = 5'b00110;
    localparam logic [4:0] OP_SLT   = 5'b00111;
    localparam logic [4:0] OP_SLTU  = 5'b01000;
    localparam logic [4:0] OP_SRA   = 5'b01001;
    localparam logic [4:0] OP_EQ    = 5'b01010;
    localparam logic [4:0] OP_NE    = 5'b01011;
    localparam logic [4:0] OP_LT    = 5'b01100;
    localparam logic [4:0] OP_GE    = 5'b01101;
    localparam logic [4:0] OP_LTU   = 5'b01110;
    localparam logic [4:0] OP_GEU   = 5'b01111;
    localparam logic [4:0] OP_PASSB = 5'b11000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       lat_op;

    logic [4:0]       dec_op;
    logic             dec_ill;
    logic             dec_m;
    logic             issue;
    logic [CNT_W-1:0] load_val;

    // Combinational decode of the current ID/EX fields; illegal forces ADD.
    always_comb begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        case (ALUOp)
            2'b00: dec_op = OP_ADD;
            2'b11: dec_op = OP_PASSB;
            2'b01: begin
                case (Funct3)
                    3'b000:  dec_op = OP_EQ;
                    3'b001:  dec_op = OP_NE;
                    3'b100:  dec_op = OP_LT;
                    3'b101:  dec_op = OP_GE;
                    3'b110:  dec_op = OP_LTU;
                    3'b111:  dec_op = OP_GEU;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: begin
                if (Funct7 == 7'b0000000) begin
                    case (Funct3)
                        3'b000:  dec_op = OP_ADD;
                        3'b001:  dec_op = OP_SLL;
                        3'b010:  dec_op = OP_SLT;
                        3'b011:  dec_op = OP_SLTU;
                        3'b100:  dec_op = OP_XOR;
                        3'b101:  dec_op = OP_SRL;
                        3'b110:  dec_op = OP_OR;
                        default: dec_op = OP_AND;
                    endcase
                end else if (Funct7 == 7'b0100000) begin
                    case (Funct3)
                        3'b000:  dec_op = OP_SUB;
                        3'b101:  dec_op = OP_SRA;
                        default: dec_ill = 1'b1;
                    endcase
                end else if ((Funct7 == 7'b0000001) && (EN_M != 0)) begin
                    // MUL..REMU follow Funct3 order directly.
                    dec_op = {2'b10, Funct3};
                end else begin
                    dec_ill = 1'b1;
                end
            end
        endcase
        if (dec_ill) begin
            dec_op = OP_ADD;
        end
    end

    assign dec_m = (dec_op[4:3] == 2'b10);

    // A new M op is only accepted from IDLE, never in DONE, so the held
    // instruction is not re-issued in the cycle it advances.
    assign issue = (state == S_IDLE) && in_valid && !kill && !reset && dec_m;

    // Counter preload: LAT-2, with a 2-cycle fast path for divide-by-zero.
    always_comb begin
        load_val = MUL_LOAD;
        if (dec_op[2]) begin
            if ((DIV0_FAST != 0) && b_is_zero) begin
                load_val = '0;
            end else begin
                load_val = DIV_LOAD;
            end
        end
    end

    // Sequencer FSM: IDLE -> BUSY (count down) -> DONE -> IDLE; kill aborts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            lat_op <= OP_ADD;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        lat_op <= dec_op;
                        cnt    <= load_val;
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (kill) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output selection: live decode in IDLE, latched op while sequencing.
    always_comb begin
        Operation       = OP_W'(dec_op);
        illegal         = in_valid && dec_ill;
        md_start        = issue;
        stall           = issue || (state == S_BUSY);
        busy            = (state != S_IDLE);
        md_result_valid = (state == S_DONE);
        if (state != S_IDLE) begin
            Operation = OP_W'(lat_op);
        end
    end

endmodule
